// File: rtl/slide_scan.sv
// Round-robin potentiometer scanner in front of a shared A2D interface.
// Walks NUM_CH slots, requests one conversion per slot, and stores each result
// in a per-slot register with a one-cycle update pulse.
// Optional per-slot IIR smoothing is selected with the SLIDE_SCAN_AVG_EN macro.
module slide_scan #(
  parameter int unsigned NUM_CH   = 6,
  parameter int unsigned RES_W    = 12,
  // 3 bits per slot, slot 0 in the LSBs: slots 0..5 -> channels 0,1,2,3,4,7
  parameter logic [23:0] CH_MAP   = 24'o00743210,
  parameter int unsigned SCAN_GAP = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  output logic                    strt_cnv,
  output logic [2:0]              chnnl,
  input  logic                    cnv_cmplt,
  input  logic [15:0]             res,
  output logic [NUM_CH*RES_W-1:0] pots,
  output logic [NUM_CH-1:0]       upd,
  output logic                    scan_done
);

  localparam int unsigned   IdxW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_CH - 1);
  // Only meaningful when SCAN_GAP > 0; the GAP state is unreachable otherwise.
  localparam logic [7:0]    GapLast = 8'(SCAN_GAP - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [7:0]              gap_cnt_q, gap_cnt_d;
  logic [NUM_CH*RES_W-1:0] pots_q, pots_d;
  logic [NUM_CH-1:0]       upd_q, upd_d;
  logic                    scan_done_q, scan_done_d;
  logic                    capture;
  logic [RES_W-1:0]        sample;
  logic [RES_W-1:0]        cap_val;
  logic                    unused_res;

  assign sample     = res[RES_W-1:0];
  assign unused_res = ^res;

`ifdef SLIDE_SCAN_AVG_EN
  logic [NUM_CH-1:0]       vld_q, vld_d;
  logic [RES_W-1:0]        cur_pot;
  logic                    cur_vld;
  logic signed [RES_W:0]   diff;
  logic signed [RES_W:0]   step;

  // Smoothed capture value: raw on first sample, else pot + (sample - pot)/4.
  always_comb begin
    cur_pot = '0;
    cur_vld = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_pot = pots_q[k*RES_W +: RES_W];
        cur_vld = vld_q[k];
      end
    end
    diff    = $signed({1'b0, sample}) - $signed({1'b0, cur_pot});
    step    = diff >>> 2;
    cap_val = cur_vld ? (cur_pot + step[RES_W-1:0]) : sample;
  end

  // Valid flag per slot, set by its first capture.
  always_comb begin
    vld_d = vld_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (capture && (idx_q == IdxW'(k))) vld_d[k] = 1'b1;
    end
  end

  // Valid flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end
`else
  assign cap_val = sample;
`endif

  // Channel comes from the slot index alone, so it holds from START to capture.
  always_comb begin
    chnnl = 3'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx_q == IdxW'(k)) chnnl = CH_MAP[k*3 +: 3];
    end
  end

  // FSM next state, slot capture and pulse generation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_cnt_d   = gap_cnt_q;
    pots_d      = pots_q;
    upd_d       = '0;
    scan_done_d = 1'b0;
    strt_cnv    = 1'b0;
    capture     = 1'b0;
    case (state_q)
      StIdle: begin
        if (en) state_d = StStart;
      end
      StStart: begin
        strt_cnv = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        if (cnv_cmplt) begin
          capture   = 1'b1;
          idx_d     = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
          gap_cnt_d = '0;
          if (SCAN_GAP > 0) state_d = StGap;
          else if (en)      state_d = StStart;
          else              state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          gap_cnt_d = '0;
          state_d   = en ? StStart : StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    for (int k = 0; k < NUM_CH; k++) begin
      if (capture && (idx_q == IdxW'(k))) begin
        pots_d[k*RES_W +: RES_W] = cap_val;
        upd_d[k]                 = 1'b1;
      end
    end
    scan_done_d = capture && (idx_q == IdxLast);
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      gap_cnt_q   <= '0;
      pots_q      <= '0;
      upd_q       <= '0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_cnt_q   <= gap_cnt_d;
      pots_q      <= pots_d;
      upd_q       <= upd_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign pots      = pots_q;
  assign upd       = upd_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_slide_scan.sv
// Directed bench for slide_scan: default instance plus a SCAN_GAP=3 instance.
module tb_slide_scan;

  localparam int NUM_CH = 6;
  localparam int RES_W  = 12;

  logic                    clk;
  logic                    rst_n;
  logic                    en, cnv_cmplt, strt_cnv, scan_done;
  logic [15:0]             res;
  logic [2:0]              chnnl;
  logic [NUM_CH*RES_W-1:0] pots;
  logic [NUM_CH-1:0]       upd;

  logic                    g_en, g_cnv, g_strt, g_done;
  logic [15:0]             g_res;
  logic [2:0]              g_chnnl;
  logic [NUM_CH*RES_W-1:0] g_pots;
  logic [NUM_CH-1:0]       g_upd;

  int checks = 0;
  int errors = 0;

  logic [2:0]              exp_ch [NUM_CH] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
  logic [NUM_CH*RES_W-1:0] exp_pots;

  slide_scan dut (
    .clk(clk), .rst_n(rst_n), .en(en), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res), .pots(pots), .upd(upd), .scan_done(scan_done)
  );

  slide_scan #(.SCAN_GAP(3)) dut_g (
    .clk(clk), .rst_n(rst_n), .en(g_en), .strt_cnv(g_strt), .chnnl(g_chnnl),
    .cnv_cmplt(g_cnv), .res(g_res), .pots(g_pots), .upd(g_upd), .scan_done(g_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One conversion on the default instance; A2D answers 10 cycles after strt_cnv.
  task automatic conv(input int slot, input logic [15:0] r, input logic [RES_W-1:0] ev,
                      input int drop_at);
    int n;
    n = 0;
    while (strt_cnv !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("strt_seen", strt_cnv, 1'b1);
    chk("chnnl", chnnl, exp_ch[slot]);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == drop_at) en = 1'b0;
      if (i == 1) chk("strt_one_cycle", strt_cnv, 1'b0);
    end
    chk("no_strt_in_wait", strt_cnv, 1'b0);
    chk("chnnl_stable", chnnl, exp_ch[slot]);
    cnv_cmplt = 1'b1;
    res       = r;
    tick();
    cnv_cmplt = 1'b0;
    res       = 16'h0000;
    exp_pots[slot*RES_W +: RES_W] = ev;
    chk("pots", pots, exp_pots);
    chk("upd", upd, 128'd1 << slot);
    chk("scan_done", scan_done, (slot == NUM_CH - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int          n;
    int          seen;
    rst_n = 1'b0; en = 1'b0; cnv_cmplt = 1'b0; res = '0;
    g_en = 1'b0; g_cnv = 1'b0; g_res = '0;
    exp_pots = '0;

    // Reset values before any clock edge
    #3;
    chk("rst_strt", strt_cnv, 1'b0);
    chk("rst_chnnl", chnnl, 3'd0);
    chk("rst_pots", pots, '0);
    chk("rst_upd", upd, '0);
    chk("rst_done", scan_done, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("idle_no_strt", strt_cnv, 1'b0);
    en = 1'b1;

    // Two full rounds of continuous scanning
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NUM_CH; s++) begin
        v = 16'h0AB0 + 16'(exp_ch[s]);
        conv(s, v, v[RES_W-1:0], -1);
      end
    end
    chk("slot5_ab7", pots[5*RES_W +: RES_W], 12'hAB7);

    // en dropped two cycles after strt_cnv for slot 2
    for (int s = 0; s < 2; s++) begin
      v = 16'h0AB0 + 16'(exp_ch[s]);
      conv(s, v, v[RES_W-1:0], -1);
    end
    v = 16'h0AB0 + 16'(exp_ch[2]);
    conv(2, v, v[RES_W-1:0], 2);
    chk("drop_idle_no_strt", strt_cnv, 1'b0);
    tick();
    chk("upd_one_cycle", upd, '0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (strt_cnv) seen++;
    end
    chk("idle_strt_count", seen, 0);

    // Stray completion while idle
    cnv_cmplt = 1'b1; res = 16'hFFFF;
    tick();
    cnv_cmplt = 1'b0; res = 16'h0000;
    chk("stray_idle_pots", pots, exp_pots);
    chk("stray_idle_upd", upd, '0);
    chk("stray_idle_done", scan_done, 1'b0);

    // Re-enable resumes at slot 3
    en = 1'b1;
    v = 16'h0AB0 + 16'(exp_ch[3]);
    conv(3, v, v[RES_W-1:0], -1);

    // Reset asserted mid-conversion of slot 4
    n = 0;
    while (strt_cnv !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("slot4_strt", strt_cnv, 1'b1);
    chk("slot4_chnnl", chnnl, 3'd4);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_strt", strt_cnv, 1'b0);
    chk("midrst_chnnl", chnnl, 3'd0);
    chk("midrst_pots", pots, '0);
    chk("midrst_upd", upd, '0);
    chk("midrst_done", scan_done, 1'b0);
    exp_pots = '0;
    en = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    cnv_cmplt = 1'b1; res = 16'hFFFF;
    tick();
    cnv_cmplt = 1'b0; res = 16'h0000;
    chk("stray_after_rst_pots", pots, '0);
    chk("stray_after_rst_upd", upd, '0);

    // Slot 0 samples 0x400 then 0x800
    en = 1'b1;
    conv(0, 16'h0400, 12'h400, -1);
    for (int s = 1; s < NUM_CH; s++) begin
      v = 16'h0AB0 + 16'(exp_ch[s]);
      conv(s, v, v[RES_W-1:0], -1);
    end
`ifdef SLIDE_SCAN_AVG_EN
    conv(0, 16'h0800, 12'h500, -1);
`else
    conv(0, 16'h0800, 12'h800, -1);
`endif
    en = 1'b0;

    // SCAN_GAP=3 instance: fastest completion, gap length, stray in GAP
    g_en = 1'b1;
    n = 0;
    while (g_strt !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("gap_strt_seen", g_strt, 1'b1);
    chk("gap_chnnl0", g_chnnl, 3'd0);
    tick();
    chk("gap_wait_no_strt", g_strt, 1'b0);
    g_cnv = 1'b1; g_res = 16'h0123;
    tick();
    g_cnv = 1'b0; g_res = 16'h0000;
    chk("gap_fast_upd", g_upd, 6'b000001);
    chk("gap_fast_pots", g_pots, 72'h123);
    n = 0;
    while (g_strt !== 1'b1 && n < 20) begin
      if (n == 0) begin
        g_cnv = 1'b1; g_res = 16'hFFFF;
      end
      tick();
      if (n == 0) begin
        g_cnv = 1'b0; g_res = 16'h0000;
        chk("gap_stray_upd", g_upd, '0);
      end
      n++;
    end
    chk("gap_cycles", n, 3);
    chk("gap_stray_pots", g_pots, 72'h123);
    chk("gap_next_chnnl", g_chnnl, 3'd1);
    g_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
